// File: rtl/mem_con_pkg.sv
// Shared memory-controller types: request/command encodings, FSM states and
// the physical-address field layout used by the DRAM command path.
package mem_con_pkg;

    localparam int unsigned ADDR_W = 33;
    localparam int unsigned OPER_W = 2;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned ROW_W  = 16;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned BG_W   = 3;
    localparam int unsigned CNT_W  = 9;

    // Address field positions: row | col_hi | bank | bg | col_lo | byte
    localparam int unsigned ROW_LSB   = 17;
    localparam int unsigned COLH_LSB  = 11;
    localparam int unsigned COLH_W    = 6;
    localparam int unsigned BANK_LSB  = 9;
    localparam int unsigned BG_LSB    = 6;
    localparam int unsigned COLL_LSB  = 2;
    localparam int unsigned COLL_W    = 4;

    typedef enum logic [OPER_W-1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        IFETCH  = 2'd2,
        ILLEGAL = 2'd3
    } oper_e;

    typedef enum logic [CMD_W-1:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACT       = 3'd1,
        ST_WAIT_RCD  = 3'd2,
        ST_CAS       = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_PRE       = 3'd5,
        ST_WAIT_RP   = 3'd6
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [BANK_W-1:0] bank;
        logic [BG_W-1:0]   bg;
    } dram_loc_t;

endpackage

// File: rtl/dram_addr_map.sv
// Combinational physical-address decode into DRAM row/column/bank/bank-group.
module dram_addr_map
    import mem_con_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output dram_loc_t         o_loc_c
);

    // Byte offset within a column beat carries no DRAM addressing information.
    logic w_unused_byte;
    assign w_unused_byte = ^i_addr[COLL_LSB-1:0];

    assign o_loc_c.row  = i_addr[ROW_LSB +: ROW_W];
    assign o_loc_c.col  = {i_addr[COLH_LSB +: COLH_W], i_addr[COLL_LSB +: COLL_W]};
    assign o_loc_c.bank = i_addr[BANK_LSB +: BANK_W];
    assign o_loc_c.bg   = i_addr[BG_LSB +: BG_W];

endmodule

// File: rtl/dram_cmd_seq.sv
// Single-request closed-page DRAM sequencer: pops a request, issues ACT, RD/WR
// and PRE under timing counters, then reports completion to the queue.
module dram_cmd_seq
    import mem_con_pkg::*;
#(
    parameter int unsigned T_RCD   = 39,
    parameter int unsigned T_CL    = 40,
    parameter int unsigned T_CWL   = 38,
    parameter int unsigned T_BURST = 8,
    parameter int unsigned T_RP    = 39
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPER_W-1:0] req_oper,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_type,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              done_valid,
    output logic [OPER_W-1:0] done_oper,
    output logic [ADDR_W-1:0] done_addr,
    output logic              done_err
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // Every wait must fit the 9-bit down-counter and be at least one cycle.
    if (T_RCD < 1 || T_RCD > CNT_MAX || T_CL < 1 || T_CL > CNT_MAX ||
        T_CWL < 1 || T_CWL > CNT_MAX || T_BURST < 1 || T_BURST > CNT_MAX ||
        T_RP < 1 || T_RP > CNT_MAX ||
        (T_CL + T_BURST) > CNT_MAX || (T_CWL + T_BURST) > CNT_MAX) begin : g_bad_timing
        $error("dram_cmd_seq: timing parameters must lie in 1..511");
    end

    // Counter loads give issue-to-issue distance T; wait states exit at count 1.
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RDD_LD = CNT_W'(T_CL + T_BURST - 1);
    localparam logic [CNT_W-1:0] WRD_LD = CNT_W'(T_CWL + T_BURST - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    oper_e             r_oper;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_wr;

    logic              r_req_ready;
    logic              r_cmd_valid;
    cmd_e              r_cmd_type;
    dram_loc_t         r_loc;
    logic              r_done_valid;
    oper_e             r_done_oper;
    logic [ADDR_W-1:0] r_done_addr;
    logic              r_done_err;

    dram_loc_t         w_loc;
    dram_loc_t         w_loc_nxt;
    logic              w_accept;
    logic              w_illegal;
    cmd_e              w_cmd_type;
    logic              w_cmd_valid;
    logic              w_done;

    dram_addr_map u_addr_map (
        .i_addr  (req_addr),
        .o_loc_c (w_loc)
    );

    assign w_accept  = req_valid && r_req_ready;
    assign w_illegal = w_accept && (oper_e'(req_oper) == ILLEGAL);

    // State, shared counter, request latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_oper       <= READ;
            r_addr       <= '0;
            r_is_wr      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_type   <= NOP;
            r_loc        <= '0;
            r_done_valid <= 1'b0;
            r_done_oper  <= READ;
            r_done_addr  <= '0;
            r_done_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            if (w_accept) begin
                r_oper  <= oper_e'(req_oper);
                r_addr  <= req_addr;
                r_is_wr <= (oper_e'(req_oper) == WRITE);
            end
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_cmd_valid  <= w_cmd_valid;
            r_cmd_type   <= w_cmd_type;
            r_loc        <= w_loc_nxt;
            r_done_valid <= w_done;
            r_done_err   <= w_illegal;
            if (w_done) begin
                r_done_oper <= w_illegal ? oper_e'(req_oper) : r_oper;
                r_done_addr <= w_illegal ? req_addr : r_addr;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_state_nxt = ST_ACT;
                end
            end
            ST_ACT: begin
                w_cnt_nxt   = RCD_LD;
                w_state_nxt = (T_RCD == 1) ? ST_CAS : ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_CAS;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_CAS: begin
                w_cnt_nxt   = r_is_wr ? WRD_LD : RDD_LD;
                w_state_nxt = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_PRE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_PRE: begin
                w_cnt_nxt   = RP_LD;
                w_state_nxt = (T_RP == 1) ? ST_IDLE : ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next-cycle output values, decoded from the state being entered.
    always_comb begin
        w_cmd_type = NOP;
        case (w_state_nxt)
            ST_ACT:  w_cmd_type = ACT;
            ST_CAS:  w_cmd_type = r_is_wr ? WR : RD;
            ST_PRE:  w_cmd_type = PRE;
            default: w_cmd_type = NOP;
        endcase
        w_cmd_valid = (w_cmd_type != NOP);
        w_done      = ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) || w_illegal;

        w_loc_nxt = r_loc;
        if (w_state_nxt == ST_IDLE) begin
            w_loc_nxt = '0;
        end else if (r_state == ST_IDLE) begin
            w_loc_nxt = w_loc;
        end
    end

    assign req_ready  = r_req_ready;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_type   = r_cmd_type;
    assign cmd_bg     = r_loc.bg;
    assign cmd_bank   = r_loc.bank;
    assign cmd_row    = r_loc.row;
    assign cmd_col    = r_loc.col;
    assign done_valid = r_done_valid;
    assign done_oper  = r_done_oper;
    assign done_addr  = r_done_addr;
    assign done_err   = r_done_err;

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Bench for dram_cmd_seq: directed scenarios plus a random request stream,
// checked every cycle against an event-schedule model of the request timing.
module tb_dram_cmd_seq;

    localparam int T_RCD   = 39;
    localparam int T_CL    = 40;
    localparam int T_CWL   = 38;
    localparam int T_BURST = 8;
    localparam int T_RP    = 39;
    localparam logic [32:0] ADDR0 = 33'h012345678;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_oper;
    logic [32:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done_valid;
    logic [1:0]  done_oper;
    logic [32:0] done_addr;
    logic        done_err;

    dram_cmd_seq #(
        .T_RCD   (T_RCD),
        .T_CL    (T_CL),
        .T_CWL   (T_CWL),
        .T_BURST (T_BURST),
        .T_RP    (T_RP)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_oper   (req_oper),
        .req_addr   (req_addr),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .done_valid (done_valid),
        .done_oper  (done_oper),
        .done_addr  (done_addr),
        .done_err   (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the single request in flight and the cycle it was accepted.
    bit          m_pend = 1'b0;
    logic [1:0]  m_oper = 2'd0;
    logic [32:0] m_addr = '0;
    int          m_acc  = -10;

    // Observations used by the directed latency checks.
    int last_act = -1, last_cas = -1, last_pre = -1, last_done = -1;
    int n_done = 0, n_pre = 0;
    logic [15:0] o_row;
    logic [9:0]  o_col;
    logic [1:0]  o_bank;
    logic [2:0]  o_bg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(output bit exp_ready);
        int c, act, cas, pre, dn, e_type;
        bit legal, busy, e_done;
        longint unsigned a, e_row, e_col, e_bank, e_bg;
        c      = cyc;
        a      = 64'(m_addr);
        legal  = m_pend && (m_oper != 2'd3);
        act    = m_acc + 1;
        cas    = act + T_RCD;
        pre    = cas + ((m_oper == 2'd1) ? T_CWL : T_CL) + T_BURST;
        dn     = legal ? pre + T_RP : m_acc + 1;
        busy   = legal && (c >= act) && (c < dn);
        e_done = m_pend && (c == dn);
        e_type = 0;
        if (legal) begin
            if (c == act)      e_type = 1;
            else if (c == cas) e_type = (m_oper == 2'd1) ? 3 : 2;
            else if (c == pre) e_type = 4;
        end
        e_row  = busy ? ((a >> 17) & 64'hFFFF) : 64'd0;
        e_col  = busy ? ((((a >> 11) & 64'h3F) << 4) | ((a >> 2) & 64'hF)) : 64'd0;
        e_bank = busy ? ((a >> 9) & 64'h3) : 64'd0;
        e_bg   = busy ? ((a >> 6) & 64'h7) : 64'd0;

        check("req_ready", 64'(req_ready), 64'(!busy));
        check("cmd_valid", 64'(cmd_valid), 64'(e_type != 0));
        check("cmd_type",  64'(cmd_type),  64'(e_type));
        check("cmd_row",   64'(cmd_row),   e_row);
        check("cmd_col",   64'(cmd_col),   e_col);
        check("cmd_bank",  64'(cmd_bank),  e_bank);
        check("cmd_bg",    64'(cmd_bg),    e_bg);
        check("done_valid", 64'(done_valid), 64'(e_done));
        if (e_done) begin
            check("done_oper", 64'(done_oper), 64'(m_oper));
            check("done_addr", 64'(done_addr), 64'(m_addr));
            check("done_err",  64'(done_err),  64'(m_oper == 2'd3));
        end

        if (cmd_valid && cmd_type == 3'd1) begin
            last_act = c; o_row = cmd_row; o_bank = cmd_bank; o_bg = cmd_bg;
        end
        if (cmd_valid && (cmd_type == 3'd2 || cmd_type == 3'd3)) begin
            last_cas = c; o_col = cmd_col;
        end
        if (cmd_valid && cmd_type == 3'd4) begin
            last_pre = c; n_pre++;
        end
        if (done_valid) begin
            last_done = c; n_done++;
        end
        exp_ready = !busy;
    endtask

    // One clock cycle: check outputs, then present inputs for the next edge.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [32:0] ad, output bit acc);
        bit rdy;
        @(negedge clk);
        check_cycle(rdy);
        req_valid = v;
        req_oper  = op;
        req_addr  = ad;
        acc = v && rdy && rst_n;
        if (acc) begin
            m_pend = 1'b1; m_oper = op; m_addr = ad; m_acc = cyc;
        end
    endtask

    task automatic run(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 2'd0, 33'd0, acc);
    endtask

    function automatic logic [32:0] rand_addr();
        return {1'($urandom), $urandom};
    endfunction

    task automatic directed_seq(input logic [1:0] op, input int e_cas, input int e_pre, input int e_done);
        bit acc;
        int a0;
        cycle(1'b1, op, ADDR0, acc);
        check("seq_accept", 64'(acc), 64'd1);
        a0 = m_acc;
        run(135);
        check("seq_act_lat",  64'(last_act - a0),  64'd1);
        check("seq_cas_lat",  64'(last_cas - a0),  64'(e_cas));
        check("seq_pre_lat",  64'(last_pre - a0),  64'(e_pre));
        check("seq_done_lat", 64'(last_done - a0), 64'(e_done));
        check("seq_row",  64'(o_row),  64'h091A);
        check("seq_bg",   64'(o_bg),   64'd1);
        check("seq_bank", 64'(o_bank), 64'd3);
        check("seq_col",  64'(o_col),  64'h0AE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, acc2;
        int a1, ai, ar, nd0, np0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_oper  = 2'd0;
        req_addr  = '0;
        run(3);
        rst_n = 1'b1;
        run(20);

        directed_seq(2'd0, 40, 88, 127);
        directed_seq(2'd1, 40, 86, 125);

        // Back-to-back reads with valid held high.
        nd0 = n_done;
        cycle(1'b1, 2'd0, ADDR0, acc);
        a1 = m_acc;
        acc2 = 1'b0;
        for (int i = 0; i < 300 && !acc2; i++) cycle(1'b1, 2'd0, ADDR0 ^ 33'h100000040, acc2);
        check("b2b_accepted", 64'(acc2), 64'd1);
        check("b2b_gap", 64'(m_acc - a1), 64'd127);
        run(135);
        check("b2b_act_lat", 64'(last_act - m_acc), 64'd1);
        check("b2b_dones", 64'(n_done - nd0), 64'd2);

        // Illegal operation completes at once and frees the slot next cycle.
        np0 = n_pre;
        cycle(1'b1, 2'd3, ADDR0, acc);
        ai = m_acc;
        cycle(1'b1, 2'd0, ADDR0, acc);
        check("ill_next_accept", 64'(acc), 64'd1);
        check("ill_next_acc_cyc", 64'(m_acc - ai), 64'd1);
        check("ill_done_cyc", 64'(last_done - ai), 64'd1);
        run(135);
        check("ill_pre_count", 64'(n_pre - np0), 64'd1);

        // Reset in the middle of a read abandons it.
        cycle(1'b1, 2'd0, ADDR0, acc);
        ar = m_acc;
        run(49);
        cycle(1'b0, 2'd0, 33'd0, acc);
        check("rst_at_cyc50", 64'(cyc - ar), 64'd50);
        nd0 = n_done;
        np0 = n_pre;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_type",  64'(cmd_type),  64'd0);
        check("rst_cmd_fields", 64'({cmd_bg, cmd_bank, cmd_row, cmd_col}), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_done_oper",  64'(done_oper),  64'd0);
        check("rst_done_addr",  64'(done_addr),  64'd0);
        check("rst_done_err",   64'(done_err),   64'd0);
        m_pend = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(150);
        check("rst_no_done", 64'(n_done - nd0), 64'd0);
        check("rst_no_pre",  64'(n_pre - np0),  64'd0);
        directed_seq(2'd0, 40, 88, 127);

        // Random stream; inputs churn while not ready and must be ignored.
        for (int r = 0; r < 30; r++) begin
            run($urandom_range(0, 3));
            acc = 1'b0;
            for (int i = 0; i < 300 && !acc; i++)
                cycle(1'b1, 2'($urandom_range(0, 3)), rand_addr(), acc);
            check("rand_accept", 64'(acc), 64'd1);
        end
        run(140);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_cmd_seq.md
# dram_cmd_seq

Request-consumer end of the memory-controller queue. Pops one request (operation + 33-bit physical address) at a time via valid/ready and decodes the address into DRAM fields. Issues a closed-page ACT → RD/WR → PRE command sequence under parameterised timing counters. Reports completion so the queue side can retire the entry.

## Interface
Parameters:
- T_RCD, 39, cycles from ACT to RD/WR
- T_CL, 40, read CAS latency
- T_CWL, 38, write CAS latency
- T_BURST, 8, burst length in cycles
- T_RP, 39, cycles from PRE to completion

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_oper  in  2  0 read, 1 write, 2 instruction fetch, 3 illegal
- req_addr  in  33  physical byte address
- cmd_valid  out  1  one-cycle command strobe
- cmd_type  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_bg  out  3  bank group
- cmd_bank  out  2  bank
- cmd_row  out  16  row (valid with ACT)
- cmd_col  out  10  column (valid with RD/WR)
- done_valid  out  1  one-cycle completion pulse
- done_oper  out  2  operation of completed request
- done_addr  out  33  address of completed request
- done_err  out  1  set with done_valid for illegal oper

## Operation
- Address map: row=addr[32:17], col={addr[16:11],addr[5:2]}, bank=addr[10:9], bg=addr[8:6]; addr[1:0] ignored.
- Oper 2 follows the read sequence and issues RD.
- FSM states: IDLE, ACT, WAIT_RCD, CAS, WAIT_DATA, PRE, WAIT_RP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch oper/addr/decoded fields.
  - Oper 3 goes to a one-cycle error completion: no commands, done_err=1.
  - Otherwise go to ACT.
- ACT issues ACT. WAIT_RCD counts T_RCD. CAS issues RD or WR.
- WAIT_DATA counts T_CL+T_BURST for reads and T_CWL+T_BURST for writes.
- PRE issues PRE. WAIT_RP counts T_RP, then pulses done and returns to IDLE.
- One request in flight. req_ready=0 in every state except IDLE.
- cmd_bg/bank/row/col hold latched values while busy; they are 0 in IDLE.
- cmd_type=NOP whenever cmd_valid=0.
- Down-counters are 9 bits. Every parameter and sum must be 1..511; enforce this with an elaboration-time check.

## Timing
- Reset: req_ready=1; cmd_valid=0, cmd_type=NOP, all cmd_* fields 0; done_valid=0, done_oper=0, done_addr=0, done_err=0; FSM in IDLE.
- Accept at cycle N. Then:
  - ACT at N+1.
  - RD/WR at N+1+T_RCD.
  - PRE at RD/WR cycle + T_CL+T_BURST (read) or + T_CWL+T_BURST (write).
  - done_valid at PRE cycle + T_RP.
- The FSM enters IDLE on the done cycle, so req_ready=1 in that same cycle. Back-to-back accept is allowed there, with the next ACT one cycle later. No idle gap is required.
- Illegal oper accepted at N: done_valid=1 and done_err=1 at N+1; req_ready=1 again at N+1.
- done_oper/done_addr are valid only while done_valid=1 and may hold stale values otherwise.
- req_oper/req_addr are sampled only at the handshake. Changes while not ready are ignored.
- Reset asserted mid-sequence: abandon the request immediately. No PRE and no done is emitted. Outputs take reset values asynchronously.

## Structure
- Shared package mem_con_pkg:
  - oper_e (READ, WRITE, IFETCH, ILLEGAL)
  - cmd_e (NOP, ACT, RD, WR, PRE)
  - address-field bit-position localparams
  - state enum
- Sub-module dram_addr_map: combinational 33-bit address to {row, col, bank, bg}; shared with future multi-bank schedulers.
- Top: FSM, latches, one shared down-counter.

## Test plan
- Reset then idle: req_ready=1, cmd_valid=0, done_valid=0 for 20 cycles.
- Read oper 0, addr 0x012345678, accepted at cycle 0:
  - ACT at 1 with row 0x091A, bg 1, bank 3.
  - RD at 40 with col 0x0AE.
  - PRE at 88.
  - done at 127 with done_err=0.
- Write oper 1, same address: WR at 40, PRE at 86, done at 125.
- Two reads held valid back-to-back: second accepted at cycle 127, its ACT at 128; exactly one done per request.
- Oper 3 accepted at 0: no cmd_valid; done_valid=1 and done_err=1 at 1; next request accepted at 1.
- rst_n low at cycle 50 of a read: outputs immediately at reset values; no PRE and no done afterwards; after release, a new read completes with nominal latency.
